pe_stream_sink: RTL and testbench

Four-lane frame receiver and checker terminating the PE output stream (Q/Q_VALID/Q_BP/Q_SOF side of a PE such as the add-one engine). Each lane accepts one armed frame of a header word plus LEN payload words, checks the header against an expected destination and each payload word against an arithmetic pattern, and reports completion, word counts and sticky error flags. It sits at the tail of PE simulation and loopback builds, mirroring the DEST/LEN/GO frame generator on the input side.

---
 rtl/pe_stream_pkg.sv | 28 ++
 rtl/pe_stream_sink_if.sv | 30 +++
 rtl/pe_sink_lane.sv | 122 ++++++++++++
 rtl/pe_stream_sink.sv | 39 +++
 tb/tb_pe_stream_sink.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_stream_pkg.sv
// Shared types and constants for the PE stream sink: lane FSM states, error bit positions
// and the throttle LFSR definition.
package pe_stream_pkg;

  localparam int unsigned LanesDef = 4;
  localparam int unsigned WDef     = 64;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StPay,
    StDone
  } lane_state_e;

  localparam int unsigned ErrHdr    = 0;
  localparam int unsigned ErrNoSof  = 1;
  localparam int unsigned ErrSofPay = 2;
  localparam int unsigned ErrPay    = 3;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/pe_stream_sink_if.sv
// Bundle of the per-lane stream, arm and status signals between a PE output and the sink.
interface pe_stream_sink_if
  import pe_stream_pkg::*;
#(
  parameter int unsigned LANES = LanesDef,
  parameter int unsigned W     = WDef
);

  logic [LANES-1:0][W-1:0]  d;
  logic [LANES-1:0]         d_valid;
  logic [LANES-1:0]         d_sof;
  logic [LANES-1:0]         d_bp;
  logic [LANES-1:0][W-1:0]  dest;
  logic [LANES-1:0][31:0]   len;
  logic [LANES-1:0]         go;
  logic [LANES-1:0]         done;
  logic [LANES-1:0][3:0]    err;
  logic [LANES-1:0][31:0]   wcnt;

  modport master (
    output d, d_valid, d_sof, dest, len, go,
    input  d_bp, done, err, wcnt
  );

  modport slave (
    input  d, d_valid, d_sof, dest, len, go,
    output d_bp, done, err, wcnt
  );

endinterface

// File: rtl/pe_sink_lane.sv
// One sink lane: header/payload checker FSM with word counter and sticky error flags.
// Optional random backpressure when PE_SINK_RANDBP_EN is defined.
module pe_sink_lane
  import pe_stream_pkg::*;
#(
  parameter int unsigned W     = WDef,
  parameter int unsigned DELTA = 1
`ifdef PE_SINK_RANDBP_EN
  ,
  parameter int unsigned LANE_IDX = 0
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  input  logic         i_d_valid,
  input  logic         i_d_sof,
  output logic         o_d_bp,
  input  logic [W-1:0] i_dest,
  input  logic [31:0]  i_len,
  input  logic         i_go,
  output logic         o_done,
  output logic [3:0]   o_err,
  output logic [31:0]  o_wcnt
);

  lane_state_e  r_state;
  logic [W-1:0] r_dest;
  logic [31:0]  r_len;
  logic [31:0]  r_wcnt;
  logic         r_bp;
  logic         r_done;
  logic [3:0]   r_err;

  logic         w_xfer;
  logic         w_thr;
  logic [31:0]  w_wcnt_inc;
  logic [W-1:0] w_expect;

  assign w_xfer     = i_d_valid & ~r_bp;
  assign w_wcnt_inc = r_wcnt + 32'd1;
  assign w_expect   = W'(r_wcnt) + W'(DELTA);

`ifdef PE_SINK_RANDBP_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  // Backpressure is registered, so throttle from the value the LFSR holds next cycle.
  assign w_thr      = (w_lfsr_nxt[1:0] == 2'b00);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_lfsr <= LfsrSeed ^ 16'(LANE_IDX);
    else       r_lfsr <= w_lfsr_nxt;
  end
`else
  assign w_thr = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_dest  <= '0;
      r_len   <= '0;
      r_wcnt  <= '0;
      r_bp    <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= '0;
    end else if (i_go) begin
      // Arms from any state; an in-flight frame is abandoned.
      r_state <= StHdr;
      r_dest  <= i_dest;
      r_len   <= i_len;
      r_wcnt  <= '0;
      r_err   <= '0;
      r_done  <= 1'b0;
      r_bp    <= w_thr;
    end else begin
      unique case (r_state)
        StIdle: r_bp <= 1'b1;
        StHdr: begin
          r_bp <= w_thr;
          if (w_xfer) begin
            r_err[ErrHdr]   <= r_err[ErrHdr] | (i_d != r_dest);
            r_err[ErrNoSof] <= r_err[ErrNoSof] | ~i_d_sof;
            if (r_len == 32'd0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_bp    <= 1'b1;
            end else begin
              r_state <= StPay;
            end
          end
        end
        StPay: begin
          r_bp <= w_thr;
          if (w_xfer) begin
            r_err[ErrPay]    <= r_err[ErrPay] | (i_d != w_expect);
            r_err[ErrSofPay] <= r_err[ErrSofPay] | i_d_sof;
            r_wcnt           <= w_wcnt_inc;
            if (w_wcnt_inc == r_len) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_bp    <= 1'b1;
            end
          end
        end
        StDone: r_bp <= 1'b1;
        default: begin
          r_state <= StIdle;
          r_bp    <= 1'b1;
        end
      endcase
    end
  end

  assign o_d_bp = r_bp;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_wcnt = r_wcnt;

endmodule

// File: rtl/pe_stream_sink.sv
// Four-lane PE output stream receiver/checker; replicates pe_sink_lane per lane.
// Random source backpressure is enabled with PE_SINK_RANDBP_EN.
module pe_stream_sink
  import pe_stream_pkg::*;
#(
  parameter int unsigned LANES = LanesDef,
  parameter int unsigned W     = WDef,
  parameter int unsigned DELTA = 1
) (
  input logic             i_clk,
  input logic             i_rst,
  pe_stream_sink_if.slave s_if
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pe_sink_lane #(
      .W       (W),
      .DELTA   (DELTA)
`ifdef PE_SINK_RANDBP_EN
      ,
      .LANE_IDX(g)
`endif
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_d      (s_if.d[g]),
      .i_d_valid(s_if.d_valid[g]),
      .i_d_sof  (s_if.d_sof[g]),
      .o_d_bp   (s_if.d_bp[g]),
      .i_dest   (s_if.dest[g]),
      .i_len    (s_if.len[g]),
      .i_go     (s_if.go[g]),
      .o_done   (s_if.done[g]),
      .o_err    (s_if.err[g]),
      .o_wcnt   (s_if.wcnt[g])
    );
  end

endmodule

// File: tb/tb_pe_stream_sink.sv
// Directed self-checking bench for pe_stream_sink (default build or PE_SINK_RANDBP_EN).
module tb_pe_stream_sink;

  localparam logic [63:0] Hdr1 = 64'h0100_0000_0000_0004;
  localparam logic [63:0] Hdr2 = 64'h0200_0000_0000_0004;

  logic clk = 1'b0;
  logic rst;
  int   n_asserts = 0;
  int   n_fail    = 0;

  pe_stream_sink_if #(.LANES(4), .W(64)) u_if ();

  pe_stream_sink #(.LANES(4), .W(64), .DELTA(1)) u_dut (
    .i_clk(clk),
    .i_rst(rst),
    .s_if (u_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input logic [3:0] mask, input logic [63:0] dest, input int unsigned len);
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        u_if.dest[l] = dest;
        u_if.len[l]  = len;
        u_if.go[l]   = 1'b1;
      end
    end
    tick();
    u_if.go = '0;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
`ifndef PE_SINK_RANDBP_EN
        chk("go_bp", 64'(u_if.d_bp[l]), 64'd0);
`endif
        chk("go_done", 64'(u_if.done[l]), 64'd0);
        chk("go_wcnt", 64'(u_if.wcnt[l]), 64'd0);
      end
    end
  endtask

  // Payload position p (0-based) carries p+1; bad_k/sof_k < 0 disable those faults.
  task automatic stream(input logic [3:0] mask, input int unsigned n, input logic [63:0] hdr,
                        input bit hdr_sof, input bit gaps, input int bad_k, input int sof_k,
                        input int stop_at);
    int unsigned idx[4];
    bit          acc[4];
    bit          busy;
    int          cyc;
    cyc = 0;
    for (int l = 0; l < 4; l++) idx[l] = 0;
    forever begin
      busy = 1'b0;
      for (int l = 0; l < 4; l++) begin
        acc[l] = 1'b0;
        if (mask[l] && idx[l] <= n) begin
          busy = 1'b1;
          u_if.d_valid[l] = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (idx[l] == 0) u_if.d[l] = hdr;
          else if (int'(idx[l]) == bad_k + 1) u_if.d[l] = 64'd0;
          else u_if.d[l] = 64'(idx[l]);
          u_if.d_sof[l] = (idx[l] == 0) ? hdr_sof : (int'(idx[l]) == sof_k + 1);
          acc[l] = u_if.d_valid[l] & ~u_if.d_bp[l];
        end else begin
          u_if.d_valid[l] = 1'b0;
          u_if.d_sof[l]   = 1'b0;
        end
      end
      if (!busy) break;
      if (stop_at >= 0 && int'(idx[0]) == stop_at + 1) break;
      if (cyc >= 20000) begin
        n_asserts++;
        n_fail++;
        $error("FAIL stream_timeout: observed %0d cycles required < 20000", cyc);
        break;
      end
      tick();
      cyc++;
      for (int l = 0; l < 4; l++) if (acc[l]) idx[l]++;
    end
    u_if.d_valid = '0;
    u_if.d_sof   = '0;
  endtask

  initial begin
    rst          = 1'b1;
    u_if.d       = '0;
    u_if.d_valid = '0;
    u_if.d_sof   = '0;
    u_if.dest    = '0;
    u_if.len     = '0;
    u_if.go      = '0;
    repeat (3) tick();

    chk("rst_bp", 64'(u_if.d_bp), 64'hF);
    chk("rst_done", 64'(u_if.done), 64'h0);
    chk("rst_err", 64'(u_if.err), 64'h0);
    for (int l = 0; l < 4; l++) chk("rst_wcnt", 64'(u_if.wcnt[l]), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_bp", 64'(u_if.d_bp), 64'hF);

    // Single clean frame on lane 0.
    arm(4'h1, Hdr1, 500);
    stream(4'h1, 500, Hdr1, 1'b1, 1'b0, -1, -1, -1);
    chk("l0_done", 64'(u_if.done[0]), 64'd1);
    chk("l0_bp", 64'(u_if.d_bp[0]), 64'd1);
    chk("l0_wcnt", 64'(u_if.wcnt[0]), 64'd500);
    chk("l0_err", 64'(u_if.err[0]), 64'h0);

    // DONE holds and extra valid words are not accepted.
    u_if.d_valid[0] = 1'b1;
    u_if.d[0]       = 64'd501;
    repeat (3) tick();
    u_if.d_valid[0] = 1'b0;
    chk("hold_done", 64'(u_if.done[0]), 64'd1);
    chk("hold_wcnt", 64'(u_if.wcnt[0]), 64'd500);
    chk("hold_err", 64'(u_if.err[0]), 64'h0);

    // All lanes together with random valid gaps.
    arm(4'hF, Hdr1, 500);
    stream(4'hF, 500, Hdr1, 1'b1, 1'b1, -1, -1, -1);
    tick();
    chk("all_done", 64'(u_if.done), 64'hF);
    chk("all_err", 64'(u_if.err), 64'h0);
    for (int l = 0; l < 4; l++) chk("all_wcnt", 64'(u_if.wcnt[l]), 64'd500);

    // Header mismatch: payload still checked, frame completes.
    arm(4'h2, Hdr1, 20);
    stream(4'h2, 20, Hdr2, 1'b1, 1'b0, -1, -1, -1);
    chk("hdr_err", 64'(u_if.err[1]), 64'h1);
    chk("hdr_done", 64'(u_if.done[1]), 64'd1);
    chk("hdr_wcnt", 64'(u_if.wcnt[1]), 64'd20);

    // Missing SOF on the header.
    arm(4'h4, Hdr1, 4);
    stream(4'h4, 4, Hdr1, 1'b0, 1'b0, -1, -1, -1);
    chk("nosof_err", 64'(u_if.err[2]), 64'h2);
    chk("nosof_done", 64'(u_if.done[2]), 64'd1);

    // Corrupted payload word 37 and SOF on payload word 100.
    arm(4'h8, Hdr1, 500);
    stream(4'h8, 500, Hdr1, 1'b1, 1'b0, 37, 100, -1);
    chk("pay_err", 64'(u_if.err[3]), 64'hC);
    chk("pay_wcnt", 64'(u_if.wcnt[3]), 64'd500);
    chk("pay_done", 64'(u_if.done[3]), 64'd1);

    // Reset in the middle of a frame.
    arm(4'h1, Hdr1, 500);
    stream(4'h1, 500, Hdr1, 1'b1, 1'b0, -1, -1, 250);
    chk("mid_wcnt", 64'(u_if.wcnt[0]), 64'd250);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_bp", 64'(u_if.d_bp), 64'hF);
    chk("mrst_wcnt", 64'(u_if.wcnt[0]), 64'd0);
    chk("mrst_done", 64'(u_if.done), 64'h0);
    chk("mrst_err", 64'(u_if.err), 64'h0);
    arm(4'h1, Hdr1, 500);
    stream(4'h1, 500, Hdr1, 1'b1, 1'b0, -1, -1, -1);
    chk("rearm_done", 64'(u_if.done[0]), 64'd1);
    chk("rearm_wcnt", 64'(u_if.wcnt[0]), 64'd500);
    chk("rearm_err", 64'(u_if.err[0]), 64'h0);

    // GO during payload aborts and restarts with cleared status.
    arm(4'h2, Hdr1, 30);
    stream(4'h2, 30, Hdr2, 1'b1, 1'b0, -1, -1, 10);
    arm(4'h2, Hdr1, 30);
    chk("abort_err", 64'(u_if.err[1]), 64'h0);
    stream(4'h2, 30, Hdr1, 1'b1, 1'b0, -1, -1, -1);
    chk("abort_done", 64'(u_if.done[1]), 64'd1);
    chk("abort_wcnt", 64'(u_if.wcnt[1]), 64'd30);
    chk("abort_fin_err", 64'(u_if.err[1]), 64'h0);

    // Zero-length frame completes on the header alone.
    arm(4'h4, Hdr1, 0);
    stream(4'h4, 0, Hdr1, 1'b1, 1'b0, -1, -1, -1);
    chk("zero_done", 64'(u_if.done[2]), 64'd1);
    chk("zero_bp", 64'(u_if.d_bp[2]), 64'd1);
    chk("zero_wcnt", 64'(u_if.wcnt[2]), 64'd0);
    chk("zero_err", 64'(u_if.err[2]), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
